pc_unit: RTL and testbench
==========================

# pc_unit

- Parametrised program-counter unit for the single-cycle MIPS core, next generation of the plain PC register.
- Adds:
  - configurable width and reset/exception vectors
  - stall hold and prioritised next-PC selection (branch, jump, jr, exception, eret)
  - exception PC capture
  - a boot/run/halt state machine qualifying fetch
  - an optional return-address stack
- Feeds instruction memory and the PC+4 adder path.

## Interface
- `N`, 32: PC width in bits.
- `RESET_VEC`, 32'h0000_0000: PC value on reset.
- `EXC_VEC`, 32'h8000_0180: exception handler entry.
- `RAS_DEPTH`, 4: return-address stack entries (power of two, ≥2).

- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `stall_i`  in  1  hold PC this cycle.
- `halt_i`  in  1  enter HALTED (from RUN).
- `branch_i` / `branch_tgt_i`  in  1 / N  taken branch and its target.
- `jump_i` / `jump_tgt_i`  in  1 / N  j/jal and its target.
- `jr_i` / `jr_tgt_i`  in  1 / N  jr/jalr and its register target.
- `exc_i` / `exc_pc_i`  in  1 / N  exception request and faulting instruction address.
- `eret_i`  in  1  return from exception.
- `call_i` / `ret_i`  in  1 / 1  RAS push (jal/jalr) / pop (jr $ra).
- `pc_o`  out  N  current PC.
- `pc_plus4_o`  out  N  pc_o + 4, modulo 2^N.
- `pc_valid_o`  out  1  pc_o is a fetch address (state RUN).
- `epc_o`  out  N  captured exception PC.
- `ras_top_o` / `ras_empty_o`  out  N / 1  predicted return address / stack empty.

## Operation
- **FSM states:** BOOT, RUN, HALTED.
  - BOOT → RUN unconditionally on first edge after reset release; PC held at RESET_VEC.
  - RUN → HALTED on `halt_i` (and no `exc_i`); PC held.
  - HALTED → RUN only on `exc_i`, with PC = EXC_VEC; all other inputs ignored in HALTED.
- **Next-PC priority in RUN** (first match wins):
  1. `exc_i` → EXC_VEC, `epc` ← `exc_pc_i`
  2. `stall_i` → hold
  3. `eret_i` → `epc`
  4. `jr_i` → `jr_tgt_i`
  5. `jump_i` → `jump_tgt_i`
  6. `branch_i` → `branch_tgt_i`
  7. else → `pc_plus4`
- `exc_i` overrides `stall_i` and `halt_i`. Redirects other than `exc_i` arriving during a stall are dropped; the source re-asserts them.
- **Alignment:** bits [1:0] of every target and of `exc_pc_i` forced to 0 before use.
- **Arithmetic:** `pc_plus4` wraps 2^N−4 → 0 without flag.
- **RAS:**
  - Circular buffer, `RAS_DEPTH` entries. `call_i` pushes `pc_plus4_o`; `ret_i` pops.
  - Push when full overwrites the oldest entry; the count saturates at `RAS_DEPTH`.
  - Pop when empty is a no-op.
  - Simultaneous `call_i` and `ret_i`: top replaced by the new link, count unchanged.
  - RAS updates only on cycles where the PC advances (RUN, no stall, no `exc_i`).
  - `ras_top_o` is 0 when empty.

## Timing
- Single-cycle registered: inputs sampled at edge k, new `pc_o`/`epc_o`/RAS contents visible after edge k.
- `pc_plus4_o`, `ras_top_o`, `ras_empty_o` and `pc_valid_o` are combinational from registered state.
- **Reset values:**
  - `pc_o` = RESET_VEC; `pc_plus4_o` = RESET_VEC+4
  - `pc_valid_o` = 0; `epc_o` = 0
  - RAS empty (`ras_empty_o` = 1, `ras_top_o` = 0); state BOOT
- Reset mid-operation discards any pending redirect, the EPC and the RAS contents immediately, without waiting for a clock edge.

## Configuration
- `PC_RAS_EN` defined: RAS built as above.
- `PC_RAS_EN` undefined:
  - no RAS storage
  - `ras_top_o` tied 0, `ras_empty_o` tied 1
  - `call_i`/`ret_i` ignored
  - all other behaviour identical

## Structure
- Package `pc_unit_pkg`:
  - state enum (BOOT, RUN, HALTED)
  - default RESET_VEC/EXC_VEC constants
  - `INSTR_BYTES` = 4 constant
  - alignment mask
- Sub-module `pc_ras`: holds the stack pointer, count and entry array, with push/pop/top/empty. Instantiated only under `PC_RAS_EN`.

## Test plan
- **Reset/boot:** release `reset_n` → `pc_o`=0, `pc_valid_o`=0; after edge 1 `pc_valid_o`=1, `pc_o`=0; after edge 2 `pc_o`=4.
- **Priority:** `branch_i`(0x100), `jump_i`(0x200) and `jr_i`(0x300) together → `pc_o`=0x300. Same cycle plus `exc_i` with `exc_pc_i`=0x44 → `pc_o`=0x8000_0180, `epc_o`=0x44. Then `eret_i` → `pc_o`=0x44.
- **Stall:** `stall_i`=1 with `jump_i`(0x200) for 3 cycles → `pc_o` unchanged. Release with no redirect → `pc_o` = old+4.
- **Wrap/alignment:** jump to 0xFFFF_FFFF → `pc_o`=0xFFFF_FFFC; next cycle `pc_o`=0.
- **Halt/wake:** `halt_i` → `pc_valid_o`=0, PC frozen for 5 cycles despite `branch_i`; `exc_i` → RUN, `pc_o`=EXC_VEC.
- **RAS (with `PC_RAS_EN`, depth 4):**
  - 5 calls from PCs 0x10,0x20,0x30,0x40,0x50 → `ras_top_o`=0x54.
  - 4 pops → 0x44, 0x34, 0x24, then `ras_empty_o`=1.
  - A further pop → no change.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_unit_pkg;

    // Fetch qualification states.
    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalted
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VEC   = 32'h8000_0180;

    // Every instruction is one word; addresses are word aligned.
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] ALIGN_MASK  = ~(INSTR_BYTES - 1);

endpackage

// File: rtl/pc_unit_if.sv
// Core-side signal bundle of the PC unit. master = pipeline/control, slave = pc_unit.
interface pc_unit_if #(
    parameter int unsigned N = 32
);
    logic         stall_i;
    logic         halt_i;
    logic         branch_i;
    logic [N-1:0] branch_tgt_i;
    logic         jump_i;
    logic [N-1:0] jump_tgt_i;
    logic         jr_i;
    logic [N-1:0] jr_tgt_i;
    logic         exc_i;
    logic [N-1:0] exc_pc_i;
    logic         eret_i;
    logic         call_i;
    logic         ret_i;

    logic [N-1:0] pc_o;
    logic [N-1:0] pc_plus4_o;
    logic         pc_valid_o;
    logic [N-1:0] epc_o;
    logic [N-1:0] ras_top_o;
    logic         ras_empty_o;

    modport master (
        output stall_i, halt_i, branch_i, branch_tgt_i, jump_i, jump_tgt_i,
               jr_i, jr_tgt_i, exc_i, exc_pc_i, eret_i, call_i, ret_i,
        input  pc_o, pc_plus4_o, pc_valid_o, epc_o, ras_top_o, ras_empty_o
    );

    modport slave (
        input  stall_i, halt_i, branch_i, branch_tgt_i, jump_i, jump_tgt_i,
               jr_i, jr_tgt_i, exc_i, exc_pc_i, eret_i, call_i, ret_i,
        output pc_o, pc_plus4_o, pc_valid_o, epc_o, ras_top_o, ras_empty_o
    );

endinterface

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer, push overwrites oldest when full,
// pop on empty is a no-op, push+pop replaces the top in place.
module pc_ras #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [N-1:0] push_data_i,
    output logic [N-1:0] top_o,
    output logic         empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    logic [N-1:0]    entries_q [DEPTH];
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            wr_en;
    logic [PtrW-1:0] wr_idx;

    // Pointer/count next state and the single write port.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (push_i && pop_i) begin
            wr_en = 1'b1;
        end else if (push_i) begin
            ptr_d  = ptr_q + PtrW'(1);
            wr_en  = 1'b1;
            wr_idx = ptr_d;
            if (count_q != Full) begin
                count_d = count_q + CntW'(1);
            end
        end else if (pop_i && count_q != '0) begin
            ptr_d   = ptr_q - PtrW'(1);
            count_d = count_q - CntW'(1);
        end
    end

    // Stack state; reset drops all contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            if (wr_en) begin
                entries_q[wr_idx] <= push_data_i;
            end
        end
    end

    assign empty_o = (count_q == '0);
    assign top_o   = empty_o ? '0 : entries_q[ptr_q];

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: boot/run/halt sequencing, prioritised next-PC select,
// EPC capture and an optional return-address stack (build with PC_RAS_EN).
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned  N         = 32,
    parameter logic [N-1:0] RESET_VEC = N'(DEFAULT_RESET_VEC),
    parameter logic [N-1:0] EXC_VEC   = N'(DEFAULT_EXC_VEC),
    parameter int unsigned  RAS_DEPTH = 4
) (
    input logic      clk,
    input logic      reset_n,
    pc_unit_if.slave bus
);

    localparam logic [N-1:0] AlignMask = ~N'(INSTR_BYTES - 1);

    pc_state_e    state_q;
    logic [N-1:0] pc_q;
    logic [N-1:0] epc_q;
    logic [N-1:0] pc_plus4;
    logic [N-1:0] next_pc;

    assign pc_plus4 = pc_q + N'(INSTR_BYTES);

    // Redirect priority among non-exception sources (exc/stall/halt handled in the FSM).
    always_comb begin
        next_pc = pc_plus4;
        if (bus.eret_i) begin
            next_pc = epc_q;
        end else if (bus.jr_i) begin
            next_pc = bus.jr_tgt_i & AlignMask;
        end else if (bus.jump_i) begin
            next_pc = bus.jump_tgt_i & AlignMask;
        end else if (bus.branch_i) begin
            next_pc = bus.branch_tgt_i & AlignMask;
        end
    end

    // State machine owning PC and EPC; exceptions beat halt and stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StBoot;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    state_q <= StRun;
                end
                StRun: begin
                    if (bus.exc_i) begin
                        pc_q  <= EXC_VEC;
                        epc_q <= bus.exc_pc_i & AlignMask;
                    end else if (bus.halt_i) begin
                        state_q <= StHalted;
                    end else if (!bus.stall_i) begin
                        pc_q <= next_pc;
                    end
                end
                StHalted: begin
                    if (bus.exc_i) begin
                        state_q <= StRun;
                        pc_q    <= EXC_VEC;
                        epc_q   <= bus.exc_pc_i & AlignMask;
                    end
                end
                default: begin
                    state_q <= StBoot;
                end
            endcase
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_plus4_o = pc_plus4;
    assign bus.pc_valid_o = (state_q == StRun);
    assign bus.epc_o      = epc_q;

`ifdef PC_RAS_EN
    logic advance;

    // The stack only moves together with the PC.
    assign advance = (state_q == StRun) && !bus.exc_i && !bus.halt_i && !bus.stall_i;

    pc_ras #(
        .N     (N),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (advance && bus.call_i),
        .pop_i       (advance && bus.ret_i),
        .push_data_i (pc_plus4),
        .top_o       (bus.ras_top_o),
        .empty_o     (bus.ras_empty_o)
    );
`else
    logic unused_ras_req;

    assign unused_ras_req  = bus.call_i ^ bus.ret_i;
    assign bus.ras_top_o   = '0;
    assign bus.ras_empty_o = 1'b1;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vectors, an abstract reference model
// checked on every falling edge, plus literal spot checks.
module tb_pc_unit;

    localparam logic [31:0] RV        = 32'h0000_0000;
    localparam logic [31:0] EV        = 32'h8000_0180;
    localparam int          RAS_DEPTH = 4;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_err;

    pc_unit_if #(.N(32)) bus ();

    pc_unit #(
        .N         (32),
        .RESET_VEC (RV),
        .EXC_VEC   (EV),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: mode 0 boot, 1 run, 2 halted; RAS kept as a plain queue.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [31:0] m_ras[$];
    logic [31:0] m_link;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0;
            m_pc   = RV;
            m_epc  = 32'h0;
            m_ras.delete();
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (bus.exc_i) begin
            m_mode = 1;
            m_pc   = EV;
            m_epc  = {bus.exc_pc_i[31:2], 2'b00};
        end else if (m_mode == 1) begin
            if (bus.halt_i) begin
                m_mode = 2;
            end else if (!bus.stall_i) begin
                m_link = m_pc + 32'd4;
`ifdef PC_RAS_EN
                if (bus.call_i && bus.ret_i) begin
                    if (m_ras.size() > 0) m_ras[m_ras.size() - 1] = m_link;
                end else if (bus.call_i) begin
                    if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
                    m_ras.push_back(m_link);
                end else if (bus.ret_i) begin
                    if (m_ras.size() > 0) void'(m_ras.pop_back());
                end
`endif
                if (bus.eret_i)        m_pc = m_epc;
                else if (bus.jr_i)     m_pc = {bus.jr_tgt_i[31:2], 2'b00};
                else if (bus.jump_i)   m_pc = {bus.jump_tgt_i[31:2], 2'b00};
                else if (bus.branch_i) m_pc = {bus.branch_tgt_i[31:2], 2'b00};
                else                   m_pc = m_link;
            end
        end
    end

    // Compare every output against the model, away from the rising edge.
    always @(negedge clk) begin
        check("pc_o", bus.pc_o, m_pc);
        check("pc_plus4_o", bus.pc_plus4_o, m_pc + 32'd4);
        check("pc_valid_o", 32'(bus.pc_valid_o), 32'(m_mode == 1));
        check("epc_o", bus.epc_o, m_epc);
        check("ras_top_o", bus.ras_top_o, (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size() - 1]);
        check("ras_empty_o", 32'(bus.ras_empty_o), 32'(m_ras.size() == 0));
    end

    task automatic idle();
        bus.stall_i      = 1'b0;
        bus.halt_i       = 1'b0;
        bus.branch_i     = 1'b0;
        bus.branch_tgt_i = 32'h0;
        bus.jump_i       = 1'b0;
        bus.jump_tgt_i   = 32'h0;
        bus.jr_i         = 1'b0;
        bus.jr_tgt_i     = 32'h0;
        bus.exc_i        = 1'b0;
        bus.exc_pc_i     = 32'h0;
        bus.eret_i       = 1'b0;
        bus.call_i       = 1'b0;
        bus.ret_i        = 1'b0;
    endtask

    // One rising edge; return just after the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        idle();
        #3;
        check("rst pc", bus.pc_o, 32'h0);
        check("rst pc_plus4", bus.pc_plus4_o, 32'h4);
        check("rst valid", 32'(bus.pc_valid_o), 32'h0);
        check("rst epc", bus.epc_o, 32'h0);
        check("rst ras_empty", 32'(bus.ras_empty_o), 32'h1);
        check("rst ras_top", bus.ras_top_o, 32'h0);

        @(negedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("boot valid", 32'(bus.pc_valid_o), 32'h0);
        step();
        check("edge1 valid", 32'(bus.pc_valid_o), 32'h1);
        check("edge1 pc", bus.pc_o, 32'h0);
        step();
        check("edge2 pc", bus.pc_o, 32'h4);

        // Priority: jr beats jump beats branch.
        bus.branch_i = 1'b1; bus.branch_tgt_i = 32'h100;
        bus.jump_i   = 1'b1; bus.jump_tgt_i   = 32'h200;
        bus.jr_i     = 1'b1; bus.jr_tgt_i     = 32'h300;
        step();
        check("prio jr", bus.pc_o, 32'h300);
        bus.exc_i = 1'b1; bus.exc_pc_i = 32'h46;
        step();
        check("prio exc pc", bus.pc_o, 32'h8000_0180);
        check("prio exc epc", bus.epc_o, 32'h44);
        idle();
        bus.eret_i = 1'b1;
        step();
        check("eret pc", bus.pc_o, 32'h44);

        // Stall holds and drops the redirect.
        idle();
        bus.stall_i = 1'b1; bus.jump_i = 1'b1; bus.jump_tgt_i = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall hold", bus.pc_o, 32'h44);
        end
        idle();
        step();
        check("stall release", bus.pc_o, 32'h48);

        // Exception overrides stall, and halt in RUN.
        bus.stall_i = 1'b1; bus.exc_i = 1'b1; bus.exc_pc_i = 32'h104;
        step();
        check("exc over stall", bus.pc_o, EV);
        check("exc over stall epc", bus.epc_o, 32'h104);
        idle();
        bus.halt_i = 1'b1; bus.exc_i = 1'b1; bus.exc_pc_i = 32'h200;
        step();
        check("exc over halt valid", 32'(bus.pc_valid_o), 32'h1);
        check("exc over halt epc", bus.epc_o, 32'h200);

        // Alignment and wrap.
        idle();
        bus.jump_i = 1'b1; bus.jump_tgt_i = 32'hFFFF_FFFF;
        step();
        check("align pc", bus.pc_o, 32'hFFFF_FFFC);
        check("wrap plus4", bus.pc_plus4_o, 32'h0);
        idle();
        step();
        check("wrap pc", bus.pc_o, 32'h0);

        // Halt and wake.
        bus.halt_i = 1'b1;
        step();
        check("halt valid", 32'(bus.pc_valid_o), 32'h0);
        idle();
        bus.branch_i = 1'b1; bus.branch_tgt_i = 32'h100; bus.eret_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("halt frozen", bus.pc_o, 32'h0);
        end
        idle();
        bus.exc_i = 1'b1; bus.exc_pc_i = 32'h30;
        step();
        check("wake pc", bus.pc_o, EV);
        check("wake valid", 32'(bus.pc_valid_o), 32'h1);
        idle();
        bus.eret_i = 1'b1;
        step();
        idle();

`ifdef PC_RAS_EN
        bus.jump_i = 1'b1; bus.jump_tgt_i = 32'h10;
        step();
        for (int i = 1; i <= 5; i++) begin
            bus.call_i = 1'b1; bus.jump_i = 1'b1; bus.jump_tgt_i = 32'((i + 1) * 16);
            step();
        end
        idle();
        check("ras top after 5 calls", bus.ras_top_o, 32'h54);
        bus.ret_i = 1'b1;
        step();
        check("ras pop1", bus.ras_top_o, 32'h44);
        step();
        check("ras pop2", bus.ras_top_o, 32'h34);
        step();
        check("ras pop3", bus.ras_top_o, 32'h24);
        step();
        check("ras pop4 empty", 32'(bus.ras_empty_o), 32'h1);
        step();
        check("ras pop empty top", bus.ras_top_o, 32'h0);
        check("ras pop empty pc", bus.pc_o, 32'h74);
        idle();
        bus.call_i = 1'b1;
        step();
        check("ras push", bus.ras_top_o, 32'h78);
        bus.ret_i = 1'b1;
        step();
        check("ras call+ret top", bus.ras_top_o, 32'h7C);
        idle();
        bus.stall_i = 1'b1; bus.ret_i = 1'b1;
        step();
        check("ras stalled pop", bus.ras_top_o, 32'h7C);
`else
        bus.call_i = 1'b1;
        step();
        check("no ras top", bus.ras_top_o, 32'h0);
        check("no ras empty", 32'(bus.ras_empty_o), 32'h1);
`endif

        // Asynchronous reset mid-operation, away from any clock edge.
        idle();
        bus.exc_i = 1'b1; bus.exc_pc_i = 32'h88; bus.call_i = 1'b1;
        step();
        idle();
        bus.call_i = 1'b1;
        step();
        idle();
        reset_n = 1'b0;
        #1;
        check("async rst pc", bus.pc_o, RV);
        check("async rst epc", bus.epc_o, 32'h0);
        check("async rst valid", 32'(bus.pc_valid_o), 32'h0);
        check("async rst ras_empty", 32'(bus.ras_empty_o), 32'h1);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        step();
        check("reboot valid", 32'(bus.pc_valid_o), 32'h1);
        step();
        check("reboot pc", bus.pc_o, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
